hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/data_path_muxs_pkg.sv | 27 ++
 rtl/hazard_scoreboard_reg_scoreboard.sv | 48 ++++
 rtl/hazard_scoreboard.sv | 143 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_path_muxs_pkg.sv
// Package: data_path_muxs_pkg
// Shared datapath mux select and hazard FSM types.
//   pcsrc_t    - PC source select driven by the hazard unit
//   hz_state_t - hazard FSM state
//   cnt_width  - width of a pending-result counter holding max(a, b)
package data_path_muxs_pkg;

   typedef enum logic [1:0] {
      NXT = 2'd0,
      BR  = 2'd1,
      JMP = 2'd2,
      JR  = 2'd3
   } pcsrc_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SQUASH = 2'd1,
      HALTED = 2'd2
   } hz_state_t;

   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_reg_scoreboard.sv
// Module: reg_scoreboard
// Per-register pending-result counters. A counter is loaded on set and
// counts down by one on every dec_en cycle until it reaches zero.
// Register 0 never holds a pending result.
// Ports:
//   clk, n_rst       - clock, asynchronous active-low reset
//   set_en/idx/val   - load counter set_idx with set_val (wins over decrement)
//   dec_en           - decrement every nonzero counter
//   rs_idx, rt_idx   - lookup indices
//   rs_busy, rt_busy - looked-up counter is nonzero
module reg_scoreboard #(
   parameter  int unsigned NREGS = 32,
   parameter  int unsigned CW    = 1,
   localparam int unsigned RW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          set_en,
   input  logic [RW-1:0] set_idx,
   input  logic [CW-1:0] set_val,
   input  logic          dec_en,
   input  logic [RW-1:0] rs_idx,
   input  logic [RW-1:0] rt_idx,
   output logic          rs_busy,
   output logic          rt_busy
);

   logic [CW-1:0] cnt [NREGS];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int unsigned r = 0; r < NREGS; r++) cnt[r] <= '0;
      end else begin
         for (int unsigned r = 0; r < NREGS; r++) begin
            if (r == 0)
               cnt[r] <= '0;
            else if (set_en && set_idx == RW'(r))
               cnt[r] <= set_val;
            else if (dec_en && cnt[r] != '0)
               cnt[r] <= cnt[r] - CW'(1);
         end
      end
   end

   assign rs_busy = (cnt[rs_idx] != '0);
   assign rt_busy = (cnt[rt_idx] != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Module: hazard_scoreboard
// Pipeline hazard unit: tracks pending register results, stalls on RAW
// hazards, squashes wrong-path fetches after taken branches/jumps and
// freezes fetch on HALT.
// Ports:
//   CLK, nRST                - clock, asynchronous active-low reset
//   ihit, dhit               - fetch / data access complete
//   id_*                     - decoded instruction in IF/ID
//   ex_br_taken, ex_halt     - EX/MEM branch resolution and halt
//   enable_*, flush_*        - per-stage enables and bubble inserts
//   PCSrc                    - PC select
//   stall_cnt                - saturating RAW stall cycle count
module hazard_scoreboard
   import data_path_muxs_pkg::*;
#(
   parameter  int unsigned NREGS     = 32,
   parameter  int unsigned LOAD_LAT  = 1,
   parameter  int unsigned FWD_EN    = 1,
   parameter  int unsigned ALU_LAT   = 2,
   parameter  int unsigned BR_SHADOW = 1,
   localparam int unsigned RW        = $clog2(NREGS),
   localparam int unsigned CW        = cnt_width(LOAD_LAT, ALU_LAT)
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          ihit,
   input  logic          dhit,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          id_rs_used,
   input  logic          id_rt_used,
   input  logic [RW-1:0] id_rd,
   input  logic          id_wen,
   input  logic          id_is_load,
   input  logic          id_jump,
   input  logic          id_jr,
   input  logic          ex_br_taken,
   input  logic          ex_halt,
   output logic          enable_pc,
   output logic          enable_IF_ID,
   output logic          enable_ID_EX,
   output logic          enable_EX_MEM,
   output logic          enable_MEM_WB,
   output logic          flush_IF_ID,
   output logic          flush_ID_EX,
   output logic          flush_EX_MEM,
   output logic          flush_MEM_WB,
   output pcsrc_t        PCSrc,
   output logic [15:0]   stall_cnt
);

   hz_state_t     state_q, state_d;
   logic [2:0]    shadow_q, shadow_d;
   logic          rs_busy, rt_busy;
   logic          raw_stall, in_run, issue, stall_evt;
   logic [CW-1:0] set_val;

   assign in_run    = (state_q == RUN);
   assign raw_stall = id_valid & ((id_rs_used & rs_busy) | (id_rt_used & rt_busy));
   assign issue     = ihit & id_valid & ~raw_stall & in_run & ~ex_br_taken;
   assign stall_evt = ihit & raw_stall & in_run & ~ex_br_taken & ~ex_halt;

   // With forwarding, a non-load write is consumable next cycle, so the
   // counter is cleared rather than left to run down from an older load.
   assign set_val = id_is_load     ? CW'(LOAD_LAT) :
                    (FWD_EN == 0)  ? CW'(ALU_LAT)  : '0;

   reg_scoreboard #(
      .NREGS (NREGS),
      .CW    (CW)
   ) u_reg_scoreboard (
      .clk     (CLK),
      .n_rst   (nRST),
      .set_en  (issue & id_wen & (id_rd != '0)),
      .set_idx (id_rd),
      .set_val (set_val),
      .dec_en  (ihit),
      .rs_idx  (id_rs),
      .rt_idx  (id_rt),
      .rs_busy (rs_busy),
      .rt_busy (rt_busy)
   );

   always_comb begin
      enable_pc     = 1'b1;
      enable_IF_ID  = ihit;
      enable_ID_EX  = ihit;
      enable_EX_MEM = ihit | dhit;
      enable_MEM_WB = ihit | dhit;
      flush_IF_ID   = 1'b0;
      flush_ID_EX   = 1'b0;
      flush_EX_MEM  = dhit;
      flush_MEM_WB  = 1'b0;
      PCSrc         = NXT;
      state_d       = state_q;
      shadow_d      = shadow_q;

      if (ex_halt || state_q == HALTED) begin
         enable_pc   = 1'b0;
         flush_IF_ID = 1'b1;
         flush_ID_EX = 1'b1;
         state_d     = HALTED;
      end else if (ex_br_taken) begin
         PCSrc        = BR;
         flush_IF_ID  = 1'b1;
         flush_ID_EX  = 1'b1;
         flush_EX_MEM = 1'b1;
         if (BR_SHADOW > 1) begin
            state_d  = SQUASH;
            shadow_d = 3'(BR_SHADOW - 1);
         end else begin
            state_d  = RUN;
         end
      end else if (state_q == SQUASH) begin
         flush_IF_ID = 1'b1;
         if (ihit) begin
            shadow_d = shadow_q - 3'd1;
            if (shadow_q == 3'd1) state_d = RUN;
         end
      end else if (raw_stall) begin
         enable_pc    = 1'b0;
         enable_IF_ID = 1'b0;
         flush_ID_EX  = 1'b1;
      end else if (id_jump) begin
         PCSrc       = id_jr ? JR : JMP;
         flush_IF_ID = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= RUN;
         shadow_q  <= '0;
         stall_cnt <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         if (stall_evt && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench: tb_hazard_scoreboard
// Two hazard_scoreboard instances with different latency/forwarding/shadow
// settings share one stimulus stream and are checked every cycle against a
// per-instance reference model, plus directed scenarios with fixed results.
module tb_hazard_scoreboard;
   import data_path_muxs_pkg::*;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dhit, id_valid, id_rs_used, id_rt_used, id_wen, id_is_load;
   logic       id_jump, id_jr, ex_br_taken, ex_halt;
   logic [4:0] id_rs, id_rt, id_rd;

   logic a_en_pc, a_en_if, a_en_id, a_en_ex, a_en_wb, a_fl_if, a_fl_id, a_fl_ex, a_fl_wb;
   logic b_en_pc, b_en_if, b_en_id, b_en_ex, b_en_wb, b_fl_if, b_fl_id, b_fl_ex, b_fl_wb;
   pcsrc_t      a_pcsrc, b_pcsrc;
   logic [15:0] a_stall, b_stall;
   logic [10:0] oa, ob;

   int n_vec = 0;
   int n_err = 0;

   // Model configuration per instance: 0 = A, 1 = B
   int LL[2] = '{1, 3};
   int FE[2] = '{1, 0};
   int AL[2] = '{2, 2};
   int BS[2] = '{3, 1};

   // Model state: pending cycles per register, mode (0 run,1 squash,2 halted)
   int mcnt[2][32];
   int mmode[2];
   int msh[2];
   int mstall[2];

   always #5 CLK = ~CLK;

   hazard_scoreboard #(
      .NREGS(32), .LOAD_LAT(1), .FWD_EN(1), .ALU_LAT(2), .BR_SHADOW(3)
   ) u_dut_a (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .id_jump(id_jump),
      .id_jr(id_jr), .ex_br_taken(ex_br_taken), .ex_halt(ex_halt),
      .enable_pc(a_en_pc), .enable_IF_ID(a_en_if), .enable_ID_EX(a_en_id),
      .enable_EX_MEM(a_en_ex), .enable_MEM_WB(a_en_wb), .flush_IF_ID(a_fl_if),
      .flush_ID_EX(a_fl_id), .flush_EX_MEM(a_fl_ex), .flush_MEM_WB(a_fl_wb),
      .PCSrc(a_pcsrc), .stall_cnt(a_stall)
   );

   hazard_scoreboard #(
      .NREGS(32), .LOAD_LAT(3), .FWD_EN(0), .ALU_LAT(2), .BR_SHADOW(1)
   ) u_dut_b (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .id_jump(id_jump),
      .id_jr(id_jr), .ex_br_taken(ex_br_taken), .ex_halt(ex_halt),
      .enable_pc(b_en_pc), .enable_IF_ID(b_en_if), .enable_ID_EX(b_en_id),
      .enable_EX_MEM(b_en_ex), .enable_MEM_WB(b_en_wb), .flush_IF_ID(b_fl_if),
      .flush_ID_EX(b_fl_id), .flush_EX_MEM(b_fl_ex), .flush_MEM_WB(b_fl_wb),
      .PCSrc(b_pcsrc), .stall_cnt(b_stall)
   );

   assign oa = {a_en_pc, a_en_if, a_en_id, a_en_ex, a_en_wb,
                a_fl_if, a_fl_id, a_fl_ex, a_fl_wb, a_pcsrc};
   assign ob = {b_en_pc, b_en_if, b_en_id, b_en_ex, b_en_wb,
                b_fl_if, b_fl_id, b_fl_ex, b_fl_wb, b_pcsrc};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_raw(input int c);
      return id_valid && ((id_rs_used && mcnt[c][id_rs] != 0) ||
                          (id_rt_used && mcnt[c][id_rt] != 0));
   endfunction

   function automatic logic [10:0] exp_out(input int c);
      logic en_pc, en_if, f_if, f_id, f_ex;
      logic [1:0] pc;
      en_pc = 1'b1; en_if = ihit; f_if = 1'b0; f_id = 1'b0; f_ex = dhit; pc = 2'd0;
      if (ex_halt || mmode[c] == 2) begin
         en_pc = 1'b0; f_if = 1'b1; f_id = 1'b1;
      end else if (ex_br_taken) begin
         pc = 2'd1; f_if = 1'b1; f_id = 1'b1; f_ex = 1'b1;
      end else if (mmode[c] == 1) begin
         f_if = 1'b1;
      end else if (model_raw(c)) begin
         en_pc = 1'b0; en_if = 1'b0; f_id = 1'b1;
      end else if (id_jump) begin
         pc = id_jr ? 2'd3 : 2'd2; f_if = 1'b1;
      end
      return {en_pc, en_if, ihit, ihit | dhit, ihit | dhit, f_if, f_id, f_ex, 1'b0, pc};
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         for (int r = 0; r < 32; r++) mcnt[c][r] = 0;
         mmode[c] = 0; msh[c] = 0; mstall[c] = 0;
      end
   endtask

   task automatic model_step(input int c);
      bit raw, run, issue;
      int val;
      raw   = model_raw(c);
      run   = (mmode[c] == 0);
      issue = ihit && id_valid && !raw && run && !ex_br_taken;
      if (ihit && raw && run && !ex_br_taken && !ex_halt && mstall[c] < 65535) mstall[c]++;
      val = id_is_load ? LL[c] : (FE[c] == 0 ? AL[c] : 0);
      for (int r = 1; r < 32; r++) begin
         if (issue && id_wen && id_rd == r) mcnt[c][r] = val;
         else if (ihit && mcnt[c][r] > 0) mcnt[c][r]--;
      end
      if (ex_halt) mmode[c] = 2;
      else if (mmode[c] == 2) mmode[c] = 2;
      else if (ex_br_taken) begin
         if (BS[c] > 1) begin mmode[c] = 1; msh[c] = BS[c] - 1; end
         else mmode[c] = 0;
      end else if (mmode[c] == 1 && ihit) begin
         msh[c]--;
         if (msh[c] == 0) mmode[c] = 0;
      end
   endtask

   // Caller must be at the falling edge: check all outputs, advance the model.
   task automatic tick();
      check("outA", 32'(oa), 32'(exp_out(0)));
      check("outB", 32'(ob), 32'(exp_out(1)));
      check("stall_cntA", 32'(a_stall), 32'(mstall[0]));
      check("stall_cntB", 32'(b_stall), 32'(mstall[1]));
      model_step(0);
      model_step(1);
      @(posedge CLK);
      #1;
   endtask

   task automatic cyc();
      @(negedge CLK);
      tick();
   endtask

   task automatic idle_inputs();
      ihit = 1'b1; dhit = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
      id_rs_used = 1'b0; id_rt_used = 1'b0; id_wen = 1'b0; id_is_load = 1'b0;
      id_jump = 1'b0; id_jr = 1'b0; ex_br_taken = 1'b0; ex_halt = 1'b0;
   endtask

   task automatic instr(input bit load, input bit wen, input int rd, input bit rsu, input int rs);
      id_valid = 1'b1; id_is_load = load; id_wen = wen; id_rd = 5'(rd);
      id_rs_used = rsu; id_rs = 5'(rs); id_rt_used = 1'b0; id_rt = '0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      model_reset();
      #2;
      nRST = 1'b1;
   endtask

   task automatic rand_inputs();
      ihit        = ($urandom_range(3) != 0);
      dhit        = $urandom_range(1);
      id_valid    = $urandom_range(1);
      id_rs       = 5'($urandom_range(7));
      id_rt       = 5'($urandom_range(7));
      id_rd       = 5'($urandom_range(7));
      id_rs_used  = $urandom_range(1);
      id_rt_used  = $urandom_range(1);
      id_wen      = $urandom_range(1);
      id_is_load  = $urandom_range(1);
      id_jump     = id_valid && ($urandom_range(9) == 0);
      id_jr       = $urandom_range(1);
      ex_br_taken = ($urandom_range(15) == 0);
      ex_halt     = 1'b0;
   endtask

   initial begin
      idle_inputs();
      nRST = 1'b0;
      model_reset();
      #3;
      check("rst_stallA", 32'(a_stall), 32'd0);
      check("rst_outA", 32'(oa), 32'(exp_out(0)));
      @(posedge CLK); #1;
      nRST = 1'b1;

      // Load r5 then use r5
      instr(1, 1, 5, 0, 0); cyc();
      instr(0, 1, 6, 1, 5);
      @(negedge CLK);
      check("ld_use_pcA", 32'(a_en_pc), 32'd0);
      check("ld_use_flA", 32'(a_fl_id), 32'd1);
      tick();
      @(negedge CLK);
      check("ld_issueA", 32'(a_en_pc), 32'd1);
      check("ld_stallA", 32'(a_stall), 32'd1);
      tick();
      idle_inputs();
      repeat (4) cyc();

      // ALU write r3 then use r3
      do_reset();
      instr(0, 1, 3, 0, 0); cyc();
      instr(0, 0, 0, 1, 3);
      @(negedge CLK);
      check("alu_fwdA", 32'(a_en_pc), 32'd1);
      check("alu_s1B", 32'(b_en_pc), 32'd0);
      tick();
      @(negedge CLK); check("alu_s2B", 32'(b_en_pc), 32'd0); tick();
      @(negedge CLK);
      check("alu_goB", 32'(b_en_pc), 32'd1);
      check("alu_cntB", 32'(b_stall), 32'd2);
      check("alu_cntA", 32'(a_stall), 32'd0);
      tick();
      idle_inputs(); cyc();

      // r0 never pending; reload of a pending register restarts its count
      do_reset();
      instr(1, 1, 0, 0, 0); cyc();
      instr(0, 0, 0, 1, 0);
      @(negedge CLK); check("r0_nostallA", 32'(a_en_pc), 32'd1); tick();
      instr(1, 1, 7, 0, 0); cyc();
      instr(1, 1, 7, 0, 0); cyc();
      instr(0, 0, 0, 1, 7);
      @(negedge CLK); check("reload_r7A", 32'(a_en_pc), 32'd0); tick();
      idle_inputs(); repeat (4) cyc();

      // Taken branch with raw stall and jump in the same cycle
      do_reset();
      instr(1, 1, 9, 0, 0); cyc();
      instr(0, 0, 0, 1, 9); id_jump = 1'b1; ex_br_taken = 1'b1;
      @(negedge CLK);
      check("br_pcsrcA", 32'(a_pcsrc), 32'd1);
      check("br_flushA", 32'({a_fl_if, a_fl_id, a_fl_ex}), 32'b111);
      check("br_pcA", 32'(a_en_pc), 32'd1);
      tick();
      idle_inputs();
      @(negedge CLK); check("sq1A", 32'(a_fl_if), 32'd1); tick();
      @(negedge CLK); check("sq2A", 32'(a_fl_if), 32'd1); tick();
      @(negedge CLK); check("sq_endA", 32'(a_fl_if), 32'd0); tick();

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         rand_inputs();
         cyc();
      end

      // Reset pulse while A is squashing
      idle_inputs(); ex_br_taken = 1'b1; cyc();
      ex_br_taken = 1'b0;
      #1 nRST = 1'b0;
      model_reset();
      #1;
      check("rst_sq_flA", 32'(a_fl_if), 32'd0);
      check("rst_sq_stA", 32'(a_stall), 32'd0);
      check("rst_sq_stB", 32'(b_stall), 32'd0);
      check("rst_sq_outA", 32'(oa), 32'(exp_out(0)));
      #1 nRST = 1'b1;
      for (int r = 0; r < 32; r++) begin
         instr(0, 0, 0, 1, r);
         @(negedge CLK);
         check("clr_A", 32'(a_en_pc), 32'd1);
         check("clr_B", 32'(b_en_pc), 32'd1);
         tick();
      end

      // Halt
      idle_inputs(); ex_halt = 1'b1; cyc();
      for (int i = 0; i < 10; i++) begin
         rand_inputs();
         @(negedge CLK);
         check("halt_pcA", 32'(a_en_pc), 32'd0);
         check("halt_pcB", 32'(b_en_pc), 32'd0);
         check("halt_ifA", 32'(a_fl_if), 32'd1);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
